// File: rtl/writeback_unit.sv
// Register-file write-port owner: round-robin merge of ALU results and load responses,
// load extraction, and the pending-write scoreboard used by decode for hazard checks.
module writeback_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_rd,
  output logic                  issue_ready,
  input  logic [4:0]            query_rs1,
  input  logic [4:0]            query_rs2,
  output logic                  hazard_rs1,
  output logic                  hazard_rs2,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [4:0]            alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [4:0]            mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [2:0]            mem_funct3,
  input  logic [1:0]            mem_offset,
  output logic [4:0]            wb_address,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_enable,
  output logic [31:0]           pending
);

  typedef enum logic [0:0] {GrantAlu, GrantMem} grant_e;

  grant_e                  last_grant_q, last_grant_d;
  logic [31:0]             pending_q, pending_d;
  logic [4:0]              wb_address_q;
  logic [DATA_WIDTH-1:0]   wb_data_q;
  logic                    wb_enable_q;

  logic                    alu_fire, mem_fire, xfer, issue_fire;
  logic [4:0]              xfer_rd;
  logic [DATA_WIDTH-1:0]   xfer_data, load_data;
  logic [7:0]              load_byte;
  logic [15:0]             load_half;

  always_comb begin
    load_byte = 8'h00;
    unique case (mem_offset)
      2'd0: load_byte = mem_data[7:0];
      2'd1: load_byte = mem_data[15:8];
      2'd2: load_byte = mem_data[23:16];
      2'd3: load_byte = mem_data[31:24];
      default: load_byte = 8'h00;
    endcase
    load_half = mem_offset[1] ? mem_data[31:16] : mem_data[15:0];
    case (mem_funct3)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'h000000, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'h0000, load_half};
      default: load_data = mem_data;
    endcase
  end

  // Ready looks only at the other source's valid, so exactly one ready drops on conflict.
  assign alu_ready = !mem_valid || (last_grant_q == GrantMem);
  assign mem_ready = !alu_valid || (last_grant_q == GrantAlu);
  assign alu_fire  = alu_valid && alu_ready;
  assign mem_fire  = mem_valid && mem_ready;
  assign xfer      = alu_fire || mem_fire;

  always_comb begin
    xfer_rd      = 5'd0;
    xfer_data    = '0;
    last_grant_d = last_grant_q;
    if (alu_fire) begin
      xfer_rd      = alu_rd;
      xfer_data    = alu_data;
      last_grant_d = GrantAlu;
    end else if (mem_fire) begin
      xfer_rd      = mem_rd;
      xfer_data    = load_data;
      last_grant_d = GrantMem;
    end
  end

  assign issue_ready = (issue_rd == 5'd0) || !pending_q[issue_rd];
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != 5'd0);

  always_comb begin
    pending_d = pending_q;
    if (xfer && (xfer_rd != 5'd0)) pending_d[xfer_rd] = 1'b0;
    if (issue_fire) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // The write register stage still counts as a hazard until the file absorbs it.
  assign hazard_rs1 = (query_rs1 != 5'd0) &&
                      (pending_q[query_rs1] || (wb_enable_q && (wb_address_q == query_rs1)));
  assign hazard_rs2 = (query_rs2 != 5'd0) &&
                      (pending_q[query_rs2] || (wb_enable_q && (wb_address_q == query_rs2)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= GrantAlu;
      pending_q    <= 32'h0;
      wb_address_q <= 5'd0;
      wb_data_q    <= '0;
      wb_enable_q  <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      wb_enable_q  <= xfer && (xfer_rd != 5'd0);
      if (xfer) begin
        wb_address_q <= xfer_rd;
        wb_data_q    <= xfer_data;
      end
    end
  end

  assign wb_address = wb_address_q;
  assign wb_data    = wb_data_q;
  assign wb_enable  = wb_enable_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a behavioural model of the write port and scoreboard.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  query_rs1, query_rs2;
  logic        hazard_rs1, hazard_rs2;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_offset;
  logic [4:0]  wb_address;
  logic [31:0] wb_data;
  logic        wb_enable;
  logic [31:0] pending;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  // Model state: what the registered outputs must hold after the last edge.
  logic [31:0] m_pend, m_data;
  logic [4:0]  m_addr;
  logic        m_en, m_last_mem;

  int cf_alu_rd [4] = '{10, 10, 11, 11};
  int cf_mem_rd [4] = '{20, 21, 21, 22};
  int cf_gmem   [4] = '{1, 0, 1, 0};
  int cf_addr   [4] = '{20, 10, 21, 11};
  int ld_f3     [5] = '{0, 4, 1, 5, 2};
  int ld_off    [5] = '{3, 2, 2, 0, 1};
  logic [31:0] ld_exp [5] = '{32'hFFFFFF80, 32'h000000F1, 32'hFFFF80F1, 32'h00007F80,
                              32'h80F17F80};

  writeback_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .query_rs1(query_rs1), .query_rs2(query_rs2),
    .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_funct3(mem_funct3), .mem_offset(mem_offset),
    .wb_address(wb_address), .wb_data(wb_data), .wb_enable(wb_enable), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] load_value(logic [31:0] w, logic [2:0] f3, logic [1:0] off);
    int unsigned b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  // Compare process: check outputs mid-cycle, then advance the model to the next edge.
  always @(negedge clk) begin
    logic        alu_turn, mem_turn, exp_ir, h1, h2, got;
    logic [4:0]  rd;
    logic [31:0] d, np;
    if (cmp_on) begin
      if (!rst) begin
        m_pend = 0; m_en = 0; m_addr = 0; m_data = 0; m_last_mem = 0;
      end
      exp_ir   = (issue_rd == 0) || !m_pend[issue_rd];
      h1       = (query_rs1 != 0) && (m_pend[query_rs1] || (m_en && m_addr == query_rs1));
      h2       = (query_rs2 != 0) && (m_pend[query_rs2] || (m_en && m_addr == query_rs2));
      alu_turn = !mem_valid || m_last_mem;
      mem_turn = !alu_valid || !m_last_mem;
      chk("m_issue_ready", issue_ready, exp_ir);
      chk("m_hazard_rs1", hazard_rs1, h1);
      chk("m_hazard_rs2", hazard_rs2, h2);
      chk("m_alu_ready", alu_ready, alu_turn);
      chk("m_mem_ready", mem_ready, mem_turn);
      chk("m_pending", pending, m_pend);
      chk("m_wb_enable", wb_enable, m_en);
      if (m_en) begin
        chk("m_wb_address", wb_address, m_addr);
        chk("m_wb_data", wb_data, m_data);
      end
      if (rst) begin
        got = 0; rd = 0; d = 0;
        if (alu_valid && alu_turn) begin
          got = 1; rd = alu_rd; d = alu_data; m_last_mem = 0;
        end else if (mem_valid && mem_turn) begin
          got = 1; rd = mem_rd; d = load_value(mem_data, mem_funct3, mem_offset); m_last_mem = 1;
        end
        np = m_pend;
        if (got && rd != 0) np[rd] = 1'b0;
        if (issue_valid && exp_ir && issue_rd != 0) np[issue_rd] = 1'b1;
        m_pend = np;
        m_en   = got && (rd != 0);
        if (got) begin
          m_addr = rd;
          m_data = d;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    issue_valid = 0; issue_rd = 0; query_rs1 = 0; query_rs2 = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0; mem_funct3 = 3'b010; mem_offset = 0;
    #1 rst = 1'b0;
    cyc();
    cmp_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pending", pending, 32'h0);
    chk("reset_wb_enable", wb_enable, 0);
    chk("reset_wb_address", wb_address, 0);
    chk("reset_wb_data", wb_data, 0);
    chk("reset_issue_ready", issue_ready, 1);
    chk("reset_alu_ready", alu_ready, 1);
    chk("reset_mem_ready", mem_ready, 1);
    rst = 1'b1;
    cyc();

    // ALU RAW window
    issue_valid = 1; issue_rd = 5; query_rs1 = 5;
    cyc();
    issue_valid = 0; alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1;
    chk("raw_pending_set", pending, 32'h20);
    chk("raw_hazard_pending", hazard_rs1, 1);
    cyc();
    alu_valid = 0;
    #1;
    chk("raw_wb_enable", wb_enable, 1);
    chk("raw_wb_address", wb_address, 5);
    chk("raw_wb_data", wb_data, 32'hDEADBEEF);
    chk("raw_pending_clear", pending, 32'h0);
    chk("raw_hazard_window", hazard_rs1, 1);
    cyc();
    #1;
    chk("raw_hazard_after", hazard_rs1, 0);
    chk("raw_wb_enable_after", wb_enable, 0);
    cyc();

    // Conflict: both sources valid for four cycles, loser holds its payload
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        alu_valid = 1; alu_rd = 5'(cf_alu_rd[k]); alu_data = 32'hA000 + cf_alu_rd[k];
        mem_valid = 1; mem_rd = 5'(cf_mem_rd[k]); mem_data = 32'hB000 + cf_mem_rd[k];
        mem_funct3 = 3'b010;
      end else begin
        alu_valid = 0; mem_valid = 0;
      end
      #1;
      if (k < 4) begin
        chk("conflict_mem_ready", mem_ready, cf_gmem[k]);
        chk("conflict_alu_ready", alu_ready, 1 - cf_gmem[k]);
      end
      if (k > 0) begin
        chk("conflict_wb_enable", wb_enable, 1);
        chk("conflict_wb_address", wb_address, cf_addr[k-1]);
      end
      cyc();
    end

    // Load extraction, back to back
    mem_data = 32'h80F17F80; mem_rd = 9;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) begin
        mem_valid = 1; mem_funct3 = 3'(ld_f3[k]); mem_offset = 2'(ld_off[k]);
      end else begin
        mem_valid = 0;
      end
      #1;
      if (k > 0) chk("load_wb_data", wb_data, ld_exp[k-1]);
      cyc();
    end

    // x0 handling and WAW stall
    issue_valid = 1; issue_rd = 0;
    #1;
    chk("x0_issue_ready", issue_ready, 1);
    cyc();
    issue_valid = 0; alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
    #1;
    chk("x0_pending", pending, 32'h0);
    cyc();
    alu_valid = 0;
    #1;
    chk("x0_wb_enable", wb_enable, 0);
    cyc();
    issue_valid = 1; issue_rd = 7;
    cyc();
    #1;
    chk("waw_pending", pending, 32'h80);
    chk("waw_ready_0", issue_ready, 0);
    cyc();
    #1;
    chk("waw_ready_1", issue_ready, 0);
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    cyc();
    alu_valid = 0;
    #1;
    chk("waw_ready_after_wb", issue_ready, 1);
    chk("waw_pending_cleared", pending, 32'h0);
    cyc();
    issue_valid = 0;
    #1;
    chk("waw_reissue_pending", pending, 32'h80);
    alu_valid = 1; alu_rd = 7; alu_data = 32'h78;
    cyc();
    alu_valid = 0;
    cyc();

    // Mid-operation asynchronous reset
    issue_valid = 1; issue_rd = 5; query_rs1 = 10;
    cyc();
    issue_rd = 10; alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    cyc();
    issue_valid = 0; alu_rd = 4; alu_data = 32'h44;
    #1;
    chk("mr_pending_before", pending, 32'h420);
    chk("mr_wb_enable_before", wb_enable, 1);
    #1 rst = 1'b0;
    #1;
    chk("mr_pending_async", pending, 32'h0);
    chk("mr_wb_enable_async", wb_enable, 0);
    chk("mr_hazard_async", hazard_rs1, 0);
    chk("mr_mem_ready_async", mem_ready, 1);
    cyc();
    rst = 1'b1;
    cyc();
    alu_valid = 0;
    #1;
    chk("mr_resume_enable", wb_enable, 1);
    chk("mr_resume_address", wb_address, 4);
    chk("mr_resume_data", wb_data, 32'h44);
    cyc();

    // Randomized traffic
    repeat (3000) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                : 5'($urandom_range(0, 7));
      query_rs1   = 5'($urandom_range(0, 7));
      query_rs2   = 5'($urandom_range(0, 31));
      alu_valid   = ($urandom_range(0, 2) != 0);
      alu_rd      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                : 5'($urandom_range(0, 7));
      alu_data    = $urandom;
      mem_valid   = ($urandom_range(0, 2) != 0);
      mem_rd      = 5'($urandom_range(0, 7));
      mem_data    = $urandom;
      mem_funct3  = 3'($urandom_range(0, 7));
      mem_offset  = 2'($urandom_range(0, 3));
      rst         = ($urandom_range(0, 199) != 0);
      cyc();
    end

    rst = 1; issue_valid = 0; alu_valid = 0; mem_valid = 0;
    cyc();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
